// File: rtl/shift_arbiter_pkg.sv
// Shared ALU defines: datapath widths and shift opcode encodings.
package shift_arbiter_pkg;

  localparam int unsigned REG_WIDTH   = 32;
  localparam int unsigned SA_WIDTH    = 5;
  localparam int unsigned OPSEL_WIDTH = 3;

  typedef enum logic [OPSEL_WIDTH-1:0] {
    OP_SLL = 3'b001,
    OP_SRL = 3'b010,
    OP_ROR = 3'b011,
    OP_SRA = 3'b100,
    OP_ROL = 3'b101
  } shift_op_e;

endpackage

// File: rtl/barrel_shifter.sv
// Combinational shifter.
//   opsel   : shift opcode (see shift_arbiter_pkg)
//   sa      : shift amount, taken modulo REG_WIDTH
//   data    : operand
//   result  : shifted value, 0 for an undefined opcode
//   illegal : opcode is not a defined shift
module barrel_shifter #(
  parameter int unsigned REG_WIDTH   = shift_arbiter_pkg::REG_WIDTH,
  parameter int unsigned SA_WIDTH    = shift_arbiter_pkg::SA_WIDTH,
  parameter int unsigned OPSEL_WIDTH = shift_arbiter_pkg::OPSEL_WIDTH
) (
  input  logic [OPSEL_WIDTH-1:0] opsel,
  input  logic [SA_WIDTH-1:0]    sa,
  input  logic [REG_WIDTH-1:0]   data,
  output logic [REG_WIDTH-1:0]   result,
  output logic                   illegal
);
  import shift_arbiter_pkg::*;

  logic [31:0] amt;
  logic [31:0] inv_amt;

  // Shift counts wrap at the register width; a rotate by 0 shifts the
  // complementary half by the full width, which yields 0 and keeps data intact.
  assign amt     = 32'(sa) % 32'(REG_WIDTH);
  assign inv_amt = 32'(REG_WIDTH) - amt;

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (opsel)
      OPSEL_WIDTH'(OP_SLL): result = data << amt;
      OPSEL_WIDTH'(OP_SRL): result = data >> amt;
      OPSEL_WIDTH'(OP_SRA): result = REG_WIDTH'($signed(data) >>> amt);
      OPSEL_WIDTH'(OP_ROR): result = (data >> amt) | (data << inv_amt);
      OPSEL_WIDTH'(OP_ROL): result = (data << amt) | (data >> inv_amt);
      default:              illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end for a shared barrel shifter with a
// single-entry result register.
//   clk, rst_n          : clock, async active-low reset
//   flush               : drop held result, accept nothing this cycle
//   reqN_valid/ready    : requester handshake (ready is combinational)
//   reqN_opsel/sa/data  : requester shift operation
//   resp_valid/ready    : result register handshake
//   resp_result/id/illegal : registered shift result, granted index, bad-opcode flag
module shift_arbiter #(
  parameter int unsigned REG_WIDTH   = shift_arbiter_pkg::REG_WIDTH,
  parameter int unsigned SA_WIDTH    = shift_arbiter_pkg::SA_WIDTH,
  parameter int unsigned OPSEL_WIDTH = shift_arbiter_pkg::OPSEL_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [OPSEL_WIDTH-1:0] req0_opsel,
  input  logic [SA_WIDTH-1:0]    req0_sa,
  input  logic [REG_WIDTH-1:0]   req0_data,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [OPSEL_WIDTH-1:0] req1_opsel,
  input  logic [SA_WIDTH-1:0]    req1_sa,
  input  logic [REG_WIDTH-1:0]   req1_data,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [REG_WIDTH-1:0]   resp_result,
  output logic                   resp_id,
  output logic                   resp_illegal
);

  logic                   last_grant;
  logic                   grant_c;
  logic                   can_accept_c;
  logic                   accept_c;
  logic [OPSEL_WIDTH-1:0] mux_opsel_c;
  logic [SA_WIDTH-1:0]    mux_sa_c;
  logic [REG_WIDTH-1:0]   mux_data_c;
  logic [REG_WIDTH-1:0]   shift_result_c;
  logic                   shift_illegal_c;

  // Round-robin pick: a lone requester wins, contention goes to the one not served last.
  always_comb begin
    grant_c = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_c = ~last_grant;
    end else if (req1_valid) begin
      grant_c = 1'b1;
    end
  end

  // The register can take a new result when empty or being drained this cycle.
  assign can_accept_c = ~resp_valid | resp_ready;
  assign accept_c     = (req0_valid | req1_valid) & can_accept_c & ~flush;
  assign req0_ready   = accept_c & ~grant_c;
  assign req1_ready   = accept_c &  grant_c;

  assign mux_opsel_c = grant_c ? req1_opsel : req0_opsel;
  assign mux_sa_c    = grant_c ? req1_sa    : req0_sa;
  assign mux_data_c  = grant_c ? req1_data  : req0_data;

  barrel_shifter #(
    .REG_WIDTH   (REG_WIDTH),
    .SA_WIDTH    (SA_WIDTH),
    .OPSEL_WIDTH (OPSEL_WIDTH)
  ) u_shifter (
    .opsel   (mux_opsel_c),
    .sa      (mux_sa_c),
    .data    (mux_data_c),
    .result  (shift_result_c),
    .illegal (shift_illegal_c)
  );

  // Result register and arbitration history; flush wins over everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid   <= 1'b0;
      resp_result  <= '0;
      resp_id      <= 1'b0;
      resp_illegal <= 1'b0;
      last_grant   <= 1'b1;
    end else if (flush) begin
      resp_valid <= 1'b0;
    end else if (accept_c) begin
      resp_valid   <= 1'b1;
      resp_result  <= shift_result_c;
      resp_id      <= grant_c;
      resp_illegal <= shift_illegal_c;
      last_grant   <= grant_c;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_opsel, req1_opsel;
  logic [4:0]  req0_sa, req1_sa;
  logic [31:0] req0_data, req1_data;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_result;
  logic        resp_id, resp_illegal;

  int n_cmp;
  int n_bad;

  shift_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_opsel   (req0_opsel),
    .req0_sa      (req0_sa),
    .req0_data    (req0_data),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_opsel   (req1_opsel),
    .req1_sa      (req1_sa),
    .req1_data    (req1_data),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_result  (resp_result),
    .resp_id      (resp_id),
    .resp_illegal (resp_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; flush = 1'b0; resp_ready = 1'b0;
    req0_valid = 1'b0; req0_opsel = 3'b000; req0_sa = 5'd0; req0_data = 32'h0;
    req1_valid = 1'b0; req1_opsel = 3'b000; req1_sa = 5'd0; req1_data = 32'h0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", resp_valid); end
    n_cmp++; if (resp_result !== 32'h0) begin n_bad++; $display("FAIL reset_result got=%h exp=0", resp_result); end
    n_cmp++; if (resp_id !== 1'b0) begin n_bad++; $display("FAIL reset_id got=%b exp=0", resp_id); end
    n_cmp++; if (resp_illegal !== 1'b0) begin n_bad++; $display("FAIL reset_illegal got=%b exp=0", resp_illegal); end
    apply_reset();
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_idle_ready got=%b exp=00", {req0_ready, req1_ready}); end
  endtask

  task automatic test_single();
    apply_reset();
    req0_valid = 1'b1; req0_opsel = 3'b001; req0_sa = 5'd4; req0_data = 32'h0000000F;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_bad++; $display("FAIL single_ready got=%b exp=10", {req0_ready, req1_ready}); end
    tick();
    req0_valid = 1'b0;
    n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%b exp=1", resp_valid); end
    n_cmp++; if (resp_result !== 32'h000000F0) begin n_bad++; $display("FAIL single_result got=%h exp=000000f0", resp_result); end
    n_cmp++; if (resp_id !== 1'b0) begin n_bad++; $display("FAIL single_id got=%b exp=0", resp_id); end
    resp_ready = 1'b1;
    tick();
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain got=%b exp=0", resp_valid); end
  endtask

  task automatic test_contention();
    apply_reset();
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_opsel = 3'b011; req0_sa = 5'd1;  req0_data = 32'h80000001;
    req1_valid = 1'b1; req1_opsel = 3'b100; req1_sa = 5'd31; req1_data = 32'h80000000;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_bad++; $display("FAIL cont_ready1 got=%b exp=10", {req0_ready, req1_ready}); end
    tick();
    n_cmp++; if (resp_result !== 32'hC0000000 || resp_id !== 1'b0) begin n_bad++; $display("FAIL cont_resp1 got=%h/%b exp=c0000000/0", resp_result, resp_id); end
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b01) begin n_bad++; $display("FAIL cont_ready2 got=%b exp=01", {req0_ready, req1_ready}); end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_cmp++; if (resp_result !== 32'hFFFFFFFF || resp_id !== 1'b1 || resp_valid !== 1'b1) begin n_bad++; $display("FAIL cont_resp2 got=%h/%b/%b exp=ffffffff/1/1", resp_result, resp_id, resp_valid); end
  endtask

  // Continues from contention: register holds ffffffff/id1, last grant was req1.
  task automatic test_back_to_back();
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_opsel = 3'b001; req0_sa = 5'd1; req0_data = 32'h00000001;
    req1_valid = 1'b1; req1_opsel = 3'b010; req1_sa = 5'd1; req1_data = 32'h00000010;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL bp_ready[%0d] got=%b exp=00", i, {req0_ready, req1_ready}); end
      tick();
      n_cmp++; if (resp_valid !== 1'b1 || resp_result !== 32'hFFFFFFFF || resp_id !== 1'b1 || resp_illegal !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold[%0d] got=%b/%h/%b/%b exp=1/ffffffff/1/0", i, resp_valid, resp_result, resp_id, resp_illegal);
      end
    end
    resp_ready = 1'b1;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_bad++; $display("FAIL bp_refill_ready got=%b exp=10", {req0_ready, req1_ready}); end
    tick();
    req0_valid = 1'b0;
    n_cmp++; if (resp_valid !== 1'b1 || resp_result !== 32'h00000002 || resp_id !== 1'b0) begin n_bad++; $display("FAIL bp_refill got=%b/%h/%b exp=1/00000002/0", resp_valid, resp_result, resp_id); end
    tick();
    req1_valid = 1'b0;
    n_cmp++; if (resp_result !== 32'h00000008 || resp_id !== 1'b1) begin n_bad++; $display("FAIL bp_req1 got=%h/%b exp=00000008/1", resp_result, resp_id); end
    tick();
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain got=%b exp=0", resp_valid); end
  endtask

  task automatic test_opcodes();
    logic [2:0]  ops  [9] = '{3'b111, 3'b101, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b000, 3'b110};
    logic [4:0]  sas  [9] = '{5'd0, 5'd8, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd3};
    logic [31:0] dats [9] = '{32'h12345678, 32'h12345678, 32'hA5A5F00F, 32'hA5A5F00F, 32'hA5A5F00F,
                              32'hA5A5F00F, 32'hA5A5F00F, 32'hFFFFFFFF, 32'h00000001};
    logic [31:0] exps [9] = '{32'h0, 32'h34567812, 32'hA5A5F00F, 32'hA5A5F00F, 32'hA5A5F00F,
                              32'hA5A5F00F, 32'hA5A5F00F, 32'h0, 32'h0};
    logic        ills [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    apply_reset();
    resp_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      req1_valid = 1'b1; req1_opsel = ops[i]; req1_sa = sas[i]; req1_data = dats[i];
      tick();
      req1_valid = 1'b0;
      n_cmp++; if (resp_result !== exps[i] || resp_illegal !== ills[i] || resp_id !== 1'b1 || resp_valid !== 1'b1) begin
        n_bad++; $display("FAIL opcode[%0d] op=%b got=%h/%b/%b exp=%h/%b/1", i, ops[i], resp_result, resp_illegal, resp_id, exps[i], ills[i]);
      end
    end
  endtask

  task automatic test_flush();
    apply_reset();
    req0_valid = 1'b1; req0_opsel = 3'b001; req0_sa = 5'd2; req0_data = 32'h00000001;
    tick();
    n_cmp++; if (resp_valid !== 1'b1 || resp_result !== 32'h00000004) begin n_bad++; $display("FAIL flush_pre got=%b/%h exp=1/00000004", resp_valid, resp_result); end
    req1_valid = 1'b1; req1_opsel = 3'b010; req1_sa = 5'd4; req1_data = 32'h00000100;
    flush = 1'b1; resp_ready = 1'b1;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL flush_ready got=%b exp=00", {req0_ready, req1_ready}); end
    tick();
    flush = 1'b0;
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got=%b exp=0", resp_valid); end
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b01) begin n_bad++; $display("FAIL flush_lastgrant got=%b exp=01", {req0_ready, req1_ready}); end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_cmp++; if (resp_result !== 32'h00000010 || resp_id !== 1'b1) begin n_bad++; $display("FAIL flush_after got=%h/%b exp=00000010/1", resp_result, resp_id); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    req0_valid = 1'b1; req0_opsel = 3'b010; req0_sa = 5'd4; req0_data = 32'h000000F0;
    req1_valid = 1'b1; req1_opsel = 3'b001; req1_sa = 5'd0; req1_data = 32'h00000001;
    tick();
    n_cmp++; if (resp_valid !== 1'b1 || resp_result !== 32'h0000000F || resp_id !== 1'b0) begin n_bad++; $display("FAIL ar_pre got=%b/%h/%b exp=1/0000000f/0", resp_valid, resp_result, resp_id); end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({resp_valid, resp_id, resp_illegal} !== 3'b000 || resp_result !== 32'h0) begin
      n_bad++; $display("FAIL ar_immediate got=%b/%h/%b/%b exp=0/0/0/0", resp_valid, resp_result, resp_id, resp_illegal);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL ar_stale[%0d] got=%b exp=0", i, resp_valid); end
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_bad++; $display("FAIL ar_first_grant got=%b exp=10", {req0_ready, req1_ready}); end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_cmp++; if (resp_valid !== 1'b1 || resp_result !== 32'h0000000F || resp_id !== 1'b0) begin n_bad++; $display("FAIL ar_post got=%b/%h/%b exp=1/0000000f/0", resp_valid, resp_result, resp_id); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b1; flush = 1'b0; resp_ready = 1'b0;
    req0_valid = 1'b0; req0_opsel = 3'b000; req0_sa = 5'd0; req0_data = 32'h0;
    req1_valid = 1'b0; req1_opsel = 3'b000; req1_sa = 5'd0; req1_data = 32'h0;
    #2;
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_opcodes();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
